// File: rtl/fxp_addsub_pipe.sv
// rtl/fxp_addsub_pipe.sv - 2-stage multi-lane signed add/sub with valid/ready; FXP_ADDSUB_SAT_EN enables saturation
module fxp_addsub_pipe #(
  parameter int BIT_WIDTH = 16,
  parameter int NUM_LANES = 4
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_sub,
  input  logic [NUM_LANES*BIT_WIDTH-1:0] in_a,
  input  logic [NUM_LANES*BIT_WIDTH-1:0] in_b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_LANES*BIT_WIDTH-1:0] out_y,
  output logic [NUM_LANES-1:0]           out_ovf
);

  localparam int DW = NUM_LANES * BIT_WIDTH;

  logic          s1_valid_q, s1_valid_d;
  logic          s1_sub_q, s1_sub_d;
  logic [DW-1:0] s1_a_q, s1_a_d;
  logic [DW-1:0] s1_b_q, s1_b_d;

  logic                 out_valid_q, out_valid_d;
  logic [DW-1:0]        out_y_q, out_y_d;
  logic [NUM_LANES-1:0] out_ovf_q, out_ovf_d;

  logic s1_load, s2_load;

  logic [DW-1:0]        y_calc;
  logic [NUM_LANES-1:0] ovf_calc;
  logic [BIT_WIDTH-1:0] lane_a, lane_b;
  logic [BIT_WIDTH:0]   wide;

  // Handshake: S2 accepts when empty or draining; S1 frees up whenever it moves into S2
  always_comb begin
    s2_load  = s1_valid_q && (!out_valid_q || out_ready);
    in_ready = !s1_valid_q || s2_load;
    s1_load  = in_valid && in_ready;
  end

  // Per-lane arithmetic on the S1 operands, one bit wider so overflow shows in the top two bits
  always_comb begin
    y_calc   = '0;
    ovf_calc = '0;
    lane_a   = '0;
    lane_b   = '0;
    wide     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_a = s1_a_q[i*BIT_WIDTH +: BIT_WIDTH];
      lane_b = s1_b_q[i*BIT_WIDTH +: BIT_WIDTH];
      if (s1_sub_q) begin
        wide = {lane_a[BIT_WIDTH-1], lane_a} - {lane_b[BIT_WIDTH-1], lane_b};
      end else begin
        wide = {lane_a[BIT_WIDTH-1], lane_a} + {lane_b[BIT_WIDTH-1], lane_b};
      end
      ovf_calc[i] = wide[BIT_WIDTH] ^ wide[BIT_WIDTH-1];
`ifdef FXP_ADDSUB_SAT_EN
      if (ovf_calc[i]) begin
        y_calc[i*BIT_WIDTH +: BIT_WIDTH] = wide[BIT_WIDTH] ? {1'b1, {(BIT_WIDTH-1){1'b0}}}
                                                           : {1'b0, {(BIT_WIDTH-1){1'b1}}};
      end else begin
        y_calc[i*BIT_WIDTH +: BIT_WIDTH] = wide[BIT_WIDTH-1:0];
      end
`else
      y_calc[i*BIT_WIDTH +: BIT_WIDTH] = wide[BIT_WIDTH-1:0];
`endif
    end
  end

  // Next-state for both stages; output registers hold while stalled
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sub_d    = s1_sub_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_ovf_d   = out_ovf_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_sub_d   = in_sub;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
    if (s2_load) begin
      out_valid_d = 1'b1;
      out_y_d     = y_calc;
      out_ovf_d   = ovf_calc;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Pipeline registers with synchronous reset that drops everything in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid_q  <= 1'b0;
      s1_sub_q    <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_ovf_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sub_q    <= s1_sub_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fxp_addsub_pipe.sv
// tb/tb_fxp_addsub_pipe.sv - scoreboard bench for fxp_addsub_pipe (wrap or FXP_ADDSUB_SAT_EN build)
module tb_fxp_addsub_pipe;

  localparam int W    = 16;
  localparam int L    = 4;
  localparam int DW   = W * L;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sub = 1'b0;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_y;
  logic [L-1:0]  out_ovf;

  typedef struct packed {
    logic [DW-1:0] y;
    logic [L-1:0]  ovf;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;
  int n_in = 0;
  int n_out = 0;
  int n_stall = 0;

  always #5 CLK = ~CLK;

  fxp_addsub_pipe #(.BIT_WIDTH(W), .NUM_LANES(L)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_ovf(out_ovf)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sub);
    exp_t e;
    int sa, sb, r;
    e = '0;
    for (int i = 0; i < L; i++) begin
      sa = int'($signed(a[i*W +: W]));
      sb = int'($signed(b[i*W +: W]));
      r  = sub ? sa - sb : sa + sb;
      e.ovf[i] = (r > MAXV) || (r < MINV);
`ifdef FXP_ADDSUB_SAT_EN
      if (r > MAXV) r = MAXV;
      else if (r < MINV) r = MINV;
`endif
      e.y[i*W +: W] = r[W-1:0];
    end
    return e;
  endfunction

  // One clock: observe settled handshakes, update scoreboard, advance past the edge
  task automatic step();
    exp_t e;
    #1;
    if (out_valid === 1'b1 && out_ready) begin
      n_out++;
      if (sbq.size() == 0) begin
        check_eq("sb_pending", 64'(sbq.size() != 0), 64'd1);
      end else begin
        e = sbq.pop_front();
        check_eq("sb_y", out_y, e.y);
        check_eq("sb_ovf", 64'(out_ovf), 64'(e.ovf));
      end
    end
    if (in_valid && in_ready !== 1'b1) n_stall++;
    if (in_valid && in_ready === 1'b1) begin
      sbq.push_back(model(in_a, in_b, in_sub));
      n_in++;
    end
    @(posedge CLK);
    #1;
  endtask

  // Send one transaction and report edges from acceptance to out_valid
  task automatic send_one(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sub,
                          output int lat);
    int base;
    int guard;
    base = n_in;
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    guard = 0;
    while (n_in == base && guard < 20) begin
      step();
      guard++;
    end
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int idx;
    int base_in, base_out, base_stall, stale;
    logic [DW-1:0] ra, rb;

    // Reset then idle
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_y", out_y, 64'd0);
    check_eq("rst_out_ovf", 64'(out_ovf), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    step();
    check_eq("idle_out_valid", 64'(out_valid), 64'd0);

    // Basic sub/add with latency
    out_ready = 1'b1;
    send_one(64'h5, 64'h3, 1'b1, lat);
    check_eq("lat_sub", 64'(lat), 64'd2);
    check_eq("sub_y0", 64'(out_y[15:0]), 64'h2);
    check_eq("sub_ovf0", 64'(out_ovf[0]), 64'd0);
    step();
    send_one(64'h5, 64'h3, 1'b0, lat);
    check_eq("lat_add", 64'(lat), 64'd2);
    check_eq("add_y0", 64'(out_y[15:0]), 64'h8);
    step();

    // Subtract boundaries (lane0 0x7FFF-(-1) matches 0x7FFF+1), held with out_ready low
    out_ready = 1'b0;
    send_one(64'hFFFF_0000_8000_7FFF, 64'hFFFF_8000_0001_FFFF, 1'b1, lat);
`ifdef FXP_ADDSUB_SAT_EN
    check_eq("ovf_sub_y", out_y, 64'h0000_7FFF_8000_7FFF);
`else
    check_eq("ovf_sub_y", out_y, 64'h0000_8000_7FFF_8000);
`endif
    check_eq("ovf_sub_flags", 64'(out_ovf), 64'b0111);
    out_ready = 1'b1;
    step();

    // Add boundaries: 0x7FFF+1 and 0x8000+0x8000
    out_ready = 1'b0;
    send_one(64'h0000_0000_8000_7FFF, 64'h0000_0000_8000_0001, 1'b0, lat);
`ifdef FXP_ADDSUB_SAT_EN
    check_eq("ovf_add_y", out_y, 64'h0000_0000_8000_7FFF);
`else
    check_eq("ovf_add_y", out_y, 64'h0000_0000_0000_8000);
`endif
    check_eq("ovf_add_flags", 64'(out_ovf), 64'b0011);
    out_ready = 1'b1;
    step();

    // Backpressure: values 1..6 minus 0 with output stalled
    out_ready = 1'b0;
    base_in = n_in;
    idx = 1;
    in_sub = 1'b1;
    in_b = '0;
    for (int c = 0; c < 8; c++) begin
      in_a = {$urandom, 16'($urandom), 16'(idx)};
      in_valid = (idx <= 6);
      base_out = n_in;
      step();
      if (n_in > base_out) idx++;
      if (c == 5) begin
        check_eq("bp_accepted", 64'(n_in - base_in), 64'd2);
        check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        check_eq("bp_out_valid", 64'(out_valid), 64'd1);
        check_eq("bp_y_first", 64'(out_y[15:0]), 64'd1);
      end
    end
    check_eq("bp_y_hold", 64'(out_y[15:0]), 64'd1);
    out_ready = 1'b1;
    base_out = n_out;
    for (int c = 0; c < 6; c++) begin
      in_a = {$urandom, 16'($urandom), 16'(idx)};
      in_valid = (idx <= 6);
      base_in = n_in;
      step();
      if (n_in > base_in) idx++;
    end
    in_valid = 1'b0;
    check_eq("bp_drained_out", 64'(n_out - base_out), 64'd6);
    check_eq("bp_all_sent", 64'(idx), 64'd7);
    check_eq("bp_sb_empty", 64'(sbq.size()), 64'd0);

    // Full throughput: 100 random back-to-back
    base_in = n_in;
    base_out = n_out;
    base_stall = n_stall;
    for (int c = 0; c < 102; c++) begin
      if (n_in - base_in < 100) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        in_a = ra; in_b = rb; in_sub = 1'($urandom);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    check_eq("tp_in", 64'(n_in - base_in), 64'd100);
    check_eq("tp_out", 64'(n_out - base_out), 64'd100);
    check_eq("tp_stalls", 64'(n_stall - base_stall), 64'd0);
    check_eq("tp_sb_empty", 64'(sbq.size()), 64'd0);

    // Reset mid-stream with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_sub = 1'b0;
    in_a = {$urandom, $urandom};
    in_b = {$urandom, $urandom};
    step();
    in_a = {$urandom, $urandom};
    step();
    in_valid = 1'b0;
    check_eq("mid_full_valid", 64'(out_valid), 64'd1);
    check_eq("mid_full_in_ready", 64'(in_ready), 64'd0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    sbq.delete();
    check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (out_valid !== 1'b0) stale++;
    end
    check_eq("mid_no_stale", 64'(stale), 64'd0);
    send_one({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, lat);
    check_eq("mid_lat", 64'(lat), 64'd2);
    step();
    check_eq("mid_sb_empty", 64'(sbq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fxp_addsub_pipe.md
Name: fxp_addsub_pipe

Overview:
- Multi-lane, pipelined signed fixed-point add/subtract unit. Successor to the single-lane combinational subtractor used on filter coefficient paths.
- Adds a per-transaction add/sub mode select, a registered 2-stage pipeline with a valid/ready handshake and backpressure, and a per-lane overflow flag.
- Sits between coefficient/sample producers and the filter datapath, where the combinational subtractor could not meet timing or stall cleanly.

Parameters:
- BIT_WIDTH, 16: width of each lane's signed two's-complement operand and result.
- NUM_LANES, 4: number of independent lanes packed into each bus; must be >= 1.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- in_valid  input  1  input transaction valid.
- in_ready  output  1  unit can accept an input this cycle.
- in_sub  input  1  mode: 1 = a - b, 0 = a + b; applies to all lanes of the transaction.
- in_a  input  NUM_LANES*BIT_WIDTH  lane i occupies bits [i*BIT_WIDTH +: BIT_WIDTH], signed.
- in_b  input  NUM_LANES*BIT_WIDTH  same packing as in_a.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_y  output  NUM_LANES*BIT_WIDTH  per-lane result, same packing.
- out_ovf  output  NUM_LANES  per-lane overflow flag, aligned with out_y.

Behaviour:
- Handshakes:
  - Input transfer occurs when in_valid && in_ready at a rising edge.
  - Output transfer occurs when out_valid && out_ready at a rising edge.
- Pipeline structure:
  - Stage 1 (S1) registers in_a, in_b, in_sub and a valid bit.
  - Stage 2 (S2) registers out_y, out_ovf and out_valid, computed from S1.
- Latency: exactly 2 cycles from input transfer to out_valid, when S2 is not stalled.
- Throughput: 1 transaction per cycle while out_ready = 1.
- Advance rules:
  - S2 loads when S1 is valid and S2 is (empty or transferring out this cycle).
  - S1 loads when an input transfers.
  - in_ready = !s1_valid || s2 will load this cycle. This is a combinational path from out_ready, which is allowed.
- Stall: with out_ready = 0 and both stages full, in_ready = 0, and out_y/out_ovf/out_valid hold stable.
- Ordering and loss: no transaction is lost or duplicated, and results leave in input order.
- Simultaneous events: when both stages are full and out_ready = 1, S2 outputs, S1 moves into S2, and a new input enters S1, all in the same cycle.
- Arithmetic, per lane:
  - Sign-extend both operands to BIT_WIDTH+1 bits, then compute a+b or a-b.
  - Overflow = the two MSBs of the wide result differ.
  - out_ovf[i] is reported in both build variants.
- Mode latching: in_sub is sampled with the operands and stays tied to that transaction.
- Reset:
  - Reset values: s1_valid = 0, out_valid = 0, out_y = 0, out_ovf = 0.
  - in_ready = 1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight transactions. The output does not assert until a new input is accepted.
- Boundaries, BIT_WIDTH = 16:
  - 0x7FFF + 1 overflows.
  - 0x8000 - 1 overflows.
  - 0 - 0x8000 overflows.
  - 0x8000 + 0x8000 overflows.
  - -1 - (-1) = 0, no overflow.

Optional Feature:
- Macro: FXP_ADDSUB_SAT_EN.
- Defined: an overflowing lane clamps to the most positive value (0x7FFF) if the wide result is positive, or the most negative value (0x8000) if negative.
- Not defined: the result wraps and is the low BIT_WIDTH bits of the wide result, bit-identical to a plain BIT_WIDTH-bit adder/subtractor.
- out_ovf behaviour is identical in both cases.

Test Plan:
- Reset then idle: RST = 1 for 2 cycles, then 0 with in_valid = 0 -> out_valid = 0, out_y = 0, out_ovf = 0, in_ready = 1.
- Basic sub, lane 0, out_ready = 1: a = 0x0005, b = 0x0003, in_sub = 1 -> 2 cycles later out_y lane0 = 0x0002, ovf = 0. Same operands with in_sub = 0 -> 0x0008.
- Overflow: lane0 0x7FFF+0x0001, lane1 0x8000-0x0001, lane2 0x0000-0x8000, lane3 0xFFFF-0xFFFF:
  - Wrap build -> out_y = {0x0000, 0x8000, 0x7FFF, 0x8000} (lane3..lane0), out_ovf = 4'b0111.
  - SAT build -> out_y = {0x0000, 0x7FFF, 0x8000, 0x7FFF}, same out_ovf.
- Backpressure: stream 6 transactions with values 1..6 minus 0 and out_ready = 0 -> in_ready drops after 2 accepted, out_y holds at 1. Release out_ready -> outputs 1..6 in order with no gaps or duplicates.
- Full throughput: 100 random transactions back-to-back, in_sub random, out_ready = 1 -> one result per cycle and every result matches the reference model.
- Reset mid-stream: both stages full, assert RST for 1 cycle -> out_valid = 0 next cycle and no stale result ever appears. The next input produces its result 2 cycles after acceptance.
